pipe_arb: RTL

Two-requester round-robin arbiter fused with a single-entry pipe register, so two upstream producers can share one inter-stage pipe slot. Typical use is instruction fetch and load/store contending for a shared bus stage. The block owns the write side of the slot: it grants one requester per cycle, captures that requester's data, and tags it with the source index. It also supports multi-beat locked transfers and a flush. Downstream consumes through a valid/read handshake that obeys the same rules as every other pipe in the design.

---
 rtl/pipe_arb.sv | 116 +++++++++++
 1 files changed

// File: rtl/pipe_arb.sv
// Two-requester round-robin arbiter feeding a single-entry pipe slot, with
// multi-beat locked transfers and flush. Lock FSM and priority are exposed for debug.
module pipe_arb #(
   parameter type T = logic [7:0]
) (
   input  logic       clk_in,
   input  logic       reset_in,
   input  logic       flush_in,
   input  logic       req0_in,
   input  logic       lock0_in,
   input  T           data0_in,
   output logic       ack0_out,
   input  logic       req1_in,
   input  logic       lock1_in,
   input  T           data1_in,
   output logic       ack1_out,
   input  logic       read_in,
   output T           data_out,
   output logic       src_out,
   output logic       valid_out,
   output logic       full_out,
   output logic [1:0] dbg_state_out,
   output logic       dbg_prio_out
);

   typedef enum logic [1:0] {
      UNLOCKED = 2'd0,
      LOCKED0  = 2'd1,
      LOCKED1  = 2'd2
   } lock_state_e;

   lock_state_e state_q, state_d;
   logic        full_q, full_d;
   logic        prio_q, prio_d;
   logic        src_q, src_d;
   T            data_q, data_d;

   logic can_wr, go, elig0, elig1, r0, r1, ack0, ack1;

   // Handshakes: a beat moves from requester K to the slot in any cycle
   // where ackK_out is high; downstream takes the slot in any cycle where
   // valid_out and read_in are both high. read_in on an empty slot is ignored.
   always_comb begin
      can_wr = !full_q || read_in;
      go     = reset_in && !flush_in && can_wr;
      elig0  = (state_q != LOCKED1);
      elig1  = (state_q != LOCKED0);
      r0     = req0_in && elig0;
      r1     = req1_in && elig1;
      // prio only matters when both are eligible and requesting
      ack0   = go && r0 && (!r1 || !prio_q);
      ack1   = go && r1 && (!r0 ||  prio_q);
   end

   always_comb begin
      full_d  = full_q;
      data_d  = data_q;
      src_d   = src_q;
      prio_d  = prio_q;
      state_d = state_q;
      if (flush_in) begin
         full_d  = 1'b0;
         state_d = UNLOCKED;
      end else if (ack0) begin
         full_d = 1'b1;
         data_d = data0_in;
         src_d  = 1'b0;
         prio_d = 1'b1;
      end else if (ack1) begin
         full_d = 1'b1;
         data_d = data1_in;
         src_d  = 1'b1;
         prio_d = 1'b0;
      end else if (read_in && full_q) begin
         full_d = 1'b0;
      end

      if (!flush_in) begin
         case (state_q)
            UNLOCKED: begin
               if (ack0 && lock0_in)      state_d = LOCKED0;
               else if (ack1 && lock1_in) state_d = LOCKED1;
            end
            LOCKED0:  if (ack0 && !lock0_in) state_d = UNLOCKED;
            LOCKED1:  if (ack1 && !lock1_in) state_d = UNLOCKED;
            default:  state_d = UNLOCKED;
         endcase
      end
   end

   always_ff @(posedge clk_in) begin
      if (!reset_in) begin
         full_q  <= 1'b0;
         data_q  <= '0;
         src_q   <= 1'b0;
         prio_q  <= 1'b0;
         state_q <= UNLOCKED;
      end else begin
         full_q  <= full_d;
         data_q  <= data_d;
         src_q   <= src_d;
         prio_q  <= prio_d;
         state_q <= state_d;
      end
   end

   assign ack0_out      = ack0;
   assign ack1_out      = ack1;
   assign data_out      = data_q;
   assign src_out       = src_q;
   assign valid_out     = full_q;
   assign full_out      = full_q;
   assign dbg_state_out = state_q;
   assign dbg_prio_out  = prio_q;

endmodule
